instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/rapid_pkg.sv | 27 ++
 rtl/instruction_fetch.sv | 124 ++++++++++++
 tb/tb_instruction_fetch.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rapid_pkg.sv
// ============================================================================
// rapid_pkg : shared front-end types and constants for the rapid core
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package rapid_pkg;

  typedef enum logic [1:0] {
    FE_IDLE  = 2'd0,
    FE_REQ   = 2'd1,
    FE_ISSUE = 2'd2,
    FE_HOLD  = 2'd3
  } FE_state_t;

  typedef enum logic [1:0] {
    DE_IDLE   = 2'd0,
    DE_DECODE = 2'd1,
    DE_EXEC   = 2'd2,
    DE_DONE   = 2'd3
  } DE_state_t;

  localparam int unsigned c_PC_INCR = 4;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch : single-outstanding fetch FSM feeding one decoder slot
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module instruction_fetch
  import rapid_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pipeline_ready,
  input  logic            i_decode_done,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output FE_state_t       o_current_state,
  output FE_state_t       o_next_state
);

  FE_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] w_redirect_target;

  assign w_redirect_target = i_redirect_pc & ~XLEN'(3);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    kill_d  = kill_q;

    unique case (state_q)
      FE_IDLE: begin
        if (i_redirect) begin
          pc_d    = w_redirect_target;
          state_d = i_stall ? FE_IDLE : FE_REQ;
        end else if (!i_stall) begin
          state_d = FE_REQ;
        end
      end
      FE_REQ: begin
        if (i_redirect) pc_d = w_redirect_target;
        // A killed or same-cycle-redirected response is dropped and the fetch restarts at pc_d
        if (i_mem_ack) begin
          kill_d = 1'b0;
          if (i_redirect || kill_q) begin
            state_d = FE_REQ;
          end else begin
            state_d = FE_ISSUE;
            instr_d = i_mem_rdata;
            opc_d   = addr_q;
          end
        end else if (i_redirect) begin
          kill_d = 1'b1;
        end
      end
      FE_ISSUE: begin
        if (i_redirect) begin
          pc_d    = w_redirect_target;
          state_d = i_stall ? FE_IDLE : FE_REQ;
        end else begin
          state_d = FE_HOLD;
        end
      end
      FE_HOLD: begin
        if (i_redirect) begin
          pc_d    = w_redirect_target;
          state_d = i_stall ? FE_IDLE : FE_REQ;
        end else if (i_decode_done) begin
          pc_d    = pc_q + XLEN'(c_PC_INCR);
          state_d = i_stall ? FE_IDLE : FE_REQ;
        end
      end
    endcase

    // The bus address is frozen only while a request is still waiting for its ack
    if (state_q != FE_REQ || i_mem_ack) addr_d = pc_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= FE_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      opc_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      kill_q  <= kill_d;
    end
  end

  assign o_mem_req        = (state_q == FE_REQ);
  assign o_mem_addr       = addr_q;
  assign o_pipeline_ready = (state_q == FE_ISSUE);
  assign o_instruction    = instr_q;
  assign o_pc             = opc_q;
  assign o_current_state  = state_q;
  assign o_next_state     = state_d;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch : directed cycle table plus randomized stream vs model
// Rev 1.0              : initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;
  import rapid_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_pipeline_ready;
  logic        i_decode_done;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  FE_state_t   o_current_state;
  FE_state_t   o_next_state;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.XLEN(32), .RESET_PC(32'h20)) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .o_mem_req       (o_mem_req),
    .o_mem_addr      (o_mem_addr),
    .i_mem_ack       (i_mem_ack),
    .i_mem_rdata     (i_mem_rdata),
    .o_instruction   (o_instruction),
    .o_pc            (o_pc),
    .o_pipeline_ready(o_pipeline_ready),
    .i_decode_done   (i_decode_done),
    .i_stall         (i_stall),
    .i_redirect      (i_redirect),
    .i_redirect_pc   (i_redirect_pc),
    .o_current_state (o_current_state),
    .o_next_state    (o_next_state)
  );

  typedef struct {
    logic        rst_n, stall, redir, ack, done;
    logic [31:0] rpc, rdata;
    FE_state_t   exp_state;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_rdy;
    logic [31:0] exp_instr, exp_pc;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, input logic stall, input logic redir,
                              input logic [31:0] rpc, input logic ack, input logic [31:0] rdata,
                              input logic done, input FE_state_t st, input logic req,
                              input logic [31:0] addr, input logic rdy,
                              input logic [31:0] instr, input logic [31:0] pc);
    vec_t v;
    v.rst_n = rst_n; v.stall = stall; v.redir = redir; v.rpc = rpc; v.ack = ack;
    v.rdata = rdata; v.done = done; v.exp_state = st; v.exp_req = req; v.exp_addr = addr;
    v.exp_rdy = rdy; v.exp_instr = instr; v.exp_pc = pc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic apply_row(input vec_t v, input int idx);
    @(negedge clk);
    i_reset = v.rst_n; i_stall = v.stall; i_redirect = v.redir; i_redirect_pc = v.rpc;
    i_mem_ack = v.ack; i_mem_rdata = v.rdata; i_decode_done = v.done;
    @(posedge clk);
    #1;
    vectors++;
    if (o_current_state !== v.exp_state || o_mem_req !== v.exp_req || o_mem_addr !== v.exp_addr ||
        o_pipeline_ready !== v.exp_rdy || o_instruction !== v.exp_instr || o_pc !== v.exp_pc) begin
      errors++;
      $display("FAIL row%0d: got state=%s req=%b addr=%h rdy=%b instr=%h pc=%h; want state=%s req=%b addr=%h rdy=%b instr=%h pc=%h",
               idx, o_current_state.name(), o_mem_req, o_mem_addr, o_pipeline_ready, o_instruction, o_pc,
               v.exp_state.name(), v.exp_req, v.exp_addr, v.exp_rdy, v.exp_instr, v.exp_pc);
    end
  endtask

  // Stream run: memory with random latency, decoder with delayed done, checked against an expected-PC model
  task automatic run_stream(input int max_lat, input bit redir_en, input bit stall_en,
                            input int fixed_dly, input int n_pulses, input int budget);
    logic [31:0] exp_pc, prev_addr;
    bit          waiting, prev_req, prev_ack;
    int          pulses, cyc, lat, dcnt;
    @(negedge clk);
    i_reset = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0; i_decode_done = 1'b0;
    @(negedge clk);
    i_reset = 1'b1;
    exp_pc = 32'h20; waiting = 0; pulses = 0; cyc = 0; lat = -1; dcnt = 0;
    prev_req = 0; prev_ack = 0; prev_addr = '0;
    while (pulses < n_pulses && cyc < budget) begin
      if (prev_req && !prev_ack) begin
        vectors++;
        if (!(o_mem_req === 1'b1 && o_mem_addr === prev_addr)) begin
          errors++;
          $display("FAIL held_req cyc%0d: got req=%b addr=%h; want req=1 addr=%h", cyc, o_mem_req, o_mem_addr, prev_addr);
        end
      end
      if (o_pipeline_ready) begin
        vectors++;
        if (waiting || o_pc !== exp_pc || o_instruction !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL pulse cyc%0d: got pc=%h instr=%h dup=%0b; want pc=%h instr=%h dup=0",
                   cyc, o_pc, o_instruction, waiting, exp_pc, mem_word(exp_pc));
        end
        waiting = 1;
        dcnt = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 4));
        pulses++;
      end
      i_mem_ack = 1'b0; i_mem_rdata = '0;
      if (o_mem_req) begin
        if (lat < 0) lat = int'($urandom_range(0, max_lat));
        if (lat == 0) begin
          i_mem_ack = 1'b1; i_mem_rdata = mem_word(o_mem_addr); lat = -1;
        end else begin
          lat--;
        end
      end else begin
        lat = -1;
      end
      i_stall       = stall_en && ($urandom_range(0, 3) == 0);
      i_redirect    = redir_en && ($urandom_range(0, 15) == 0);
      i_redirect_pc = $urandom_range(32'h100, 32'h3ff);
      i_decode_done = 1'b0;
      if (waiting) begin
        if (dcnt == 0) i_decode_done = 1'b1;
        else dcnt--;
      end
      if (i_redirect) begin
        exp_pc = {i_redirect_pc[31:2], 2'b00};
        waiting = 0;
      end else if (i_decode_done) begin
        exp_pc = exp_pc + 32'd4;
        waiting = 0;
      end
      prev_req = o_mem_req; prev_ack = i_mem_ack; prev_addr = o_mem_addr;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (pulses < n_pulses) begin
      errors++;
      $display("FAIL stream_timeout: got %0d pulses; want %0d within %0d cycles", pulses, n_pulses, budget);
    end
    i_stall = 1'b0; i_redirect = 1'b0; i_mem_ack = 1'b0; i_decode_done = 1'b0;
  endtask

  initial begin
    vec_t tbl[$];
    i_reset = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0; i_decode_done = 1'b0;

    tbl.push_back(mk(0,0,0,0,0,0,0, FE_IDLE, 0,32'h20,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, FE_IDLE, 0,32'h20,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, FE_REQ,  1,32'h20,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,32'h00500613,0, FE_ISSUE,0,32'h20,1,32'h00500613,32'h20));
    tbl.push_back(mk(1,0,0,0,0,0,0, FE_HOLD, 0,32'h20,0,32'h00500613,32'h20));
    tbl.push_back(mk(1,0,0,0,0,0,0, FE_HOLD, 0,32'h20,0,32'h00500613,32'h20));
    tbl.push_back(mk(1,0,0,0,0,0,1, FE_REQ,  1,32'h24,0,32'h00500613,32'h20));
    tbl.push_back(mk(1,0,0,0,1,32'h11111111,1, FE_ISSUE,0,32'h24,1,32'h11111111,32'h24));
    tbl.push_back(mk(1,1,0,0,0,0,0, FE_HOLD, 0,32'h24,0,32'h11111111,32'h24));
    tbl.push_back(mk(1,1,0,0,0,0,1, FE_IDLE, 0,32'h28,0,32'h11111111,32'h24));
    tbl.push_back(mk(1,1,0,0,0,0,0, FE_IDLE, 0,32'h28,0,32'h11111111,32'h24));
    tbl.push_back(mk(1,0,0,0,0,0,0, FE_REQ,  1,32'h28,0,32'h11111111,32'h24));
    tbl.push_back(mk(1,0,1,32'h103,0,0,0, FE_REQ,1,32'h28,0,32'h11111111,32'h24));
    tbl.push_back(mk(1,0,0,0,1,32'hffb00613,0, FE_REQ,1,32'h100,0,32'h11111111,32'h24));
    tbl.push_back(mk(1,0,1,32'hFFFFFFFE,1,32'hAAAA0001,0, FE_REQ,1,32'hFFFFFFFC,0,32'h11111111,32'h24));
    tbl.push_back(mk(1,0,0,0,1,32'h22222222,0, FE_ISSUE,0,32'hFFFFFFFC,1,32'h22222222,32'hFFFFFFFC));
    tbl.push_back(mk(1,0,0,0,0,0,0, FE_HOLD, 0,32'hFFFFFFFC,0,32'h22222222,32'hFFFFFFFC));
    tbl.push_back(mk(1,0,0,0,0,0,1, FE_REQ,  1,32'h0,0,32'h22222222,32'hFFFFFFFC));
    tbl.push_back(mk(0,0,0,0,0,0,0, FE_IDLE, 0,32'h20,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,32'h33333333,0, FE_REQ,1,32'h20,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, FE_REQ,  1,32'h20,0,0,0));
    tbl.push_back(mk(1,0,0,0,1,32'h44444444,0, FE_ISSUE,0,32'h20,1,32'h44444444,32'h20));
    tbl.push_back(mk(1,1,1,32'h40,0,0,0, FE_IDLE,0,32'h40,0,32'h44444444,32'h20));
    tbl.push_back(mk(1,0,0,0,0,0,0, FE_REQ,  1,32'h40,0,32'h44444444,32'h20));
    tbl.push_back(mk(1,0,1,32'h80,0,0,0, FE_REQ,1,32'h40,0,32'h44444444,32'h20));
    tbl.push_back(mk(1,0,1,32'h93,0,0,0, FE_REQ,1,32'h40,0,32'h44444444,32'h20));
    tbl.push_back(mk(1,0,0,0,1,32'hDEAD0000,0, FE_REQ,1,32'h90,0,32'h44444444,32'h20));
    tbl.push_back(mk(1,0,0,0,1,32'h55555555,0, FE_ISSUE,0,32'h90,1,32'h55555555,32'h90));
    tbl.push_back(mk(1,0,1,32'h200,0,0,1, FE_REQ,1,32'h200,0,32'h55555555,32'h90));
    tbl.push_back(mk(1,0,0,0,1,32'h66666666,1, FE_ISSUE,0,32'h200,1,32'h66666666,32'h200));
    tbl.push_back(mk(1,0,0,0,0,0,0, FE_HOLD, 0,32'h200,0,32'h66666666,32'h200));
    tbl.push_back(mk(1,0,1,32'h300,0,0,1, FE_REQ,1,32'h300,0,32'h66666666,32'h200));

    foreach (tbl[i]) apply_row(tbl[i], i);

    run_stream(0, 1'b0, 1'b0, 5, 3, 200);
    run_stream(3, 1'b1, 1'b1, 0, 150, 8000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
